dmem_latency_ctrl: RTL and testbench

Multi-cycle data memory for the RISC-V CPU core. It sits directly downstream of the CPU's load/store path and replaces the zero-latency data memory: the ALU result is the address and rs2 is the store data. It accepts one word request at a time over a valid/ready handshake, holds it for a programmable latency, then performs the access and returns a one-cycle response. While a request is outstanding it drives `stall` so the CPU holds its PC and suppresses register writeback.

---
 rtl/dmem_latency_ctrl.sv | 131 +++++++++++++
 tb/tb_dmem_latency_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dmem_latency_ctrl.sv
// dmem_latency_ctrl: single-outstanding data memory for the CPU load/store path, with a programmable access latency.
// Latency: the response comes LATENCY+1 cycles after the accept edge; with DMEM_POSTED_WRITE_EN defined, aligned stores respond 1 cycle after accept.
// Backpressure: req_ready is high only in IDLE; stall holds the CPU from the request cycle through the last BUSY cycle.
module dmem_latency_ctrl #(
    parameter int DEPTH_WORDS = 16384,
    parameter int LATENCY     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [AW-1:0] lat_idx;
    logic [31:0]   lat_wdata;
    logic          lat_write;
    logic          lat_misal;

    logic [31:0]   mem [DEPTH_WORDS];
    logic          mem_we;
    logic [AW-1:0] mem_widx;
    logic [31:0]   mem_wdat;

    logic [AW-1:0] req_idx;
    logic          req_misal;
    logic          posted;
    logic          unused_addr_bits;

    assign req_idx          = req_addr[2 +: AW];
    assign req_misal        = |req_addr[1:0];
    assign unused_addr_bits = ^req_addr[31:AW+2];

`ifdef DMEM_POSTED_WRITE_EN
    assign posted = req_write & ~req_misal;
`else
    assign posted = 1'b0;
`endif

    assign stall = ((state == IDLE) && req_valid) || (state == BUSY);

    // Gating the write with reset keeps an aborted store from reaching the array.
    always_comb begin
        mem_we   = reset && (state == BUSY) && (cnt == '0) && lat_write && !lat_misal;
        mem_widx = lat_idx;
        mem_wdat = lat_wdata;
`ifdef DMEM_POSTED_WRITE_EN
        if (reset && (state == IDLE) && req_valid && posted) begin
            mem_we   = 1'b1;
            mem_widx = req_idx;
            mem_wdat = req_wdata;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdat;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            cnt        <= '0;
            lat_idx    <= '0;
            lat_wdata  <= 32'h0;
            lat_write  <= 1'b0;
            lat_misal  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_idx   <= req_idx;
                        lat_wdata <= req_wdata;
                        lat_write <= req_write;
                        lat_misal <= req_misal;
                        req_ready <= 1'b0;
                        if (posted) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= 32'h0;
                            resp_err   <= 1'b0;
                        end else begin
                            cnt   <= CNT_INIT;
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= lat_misal;
                        resp_rdata <= (lat_write || lat_misal) ? 32'h0 : mem[lat_idx];
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_latency_ctrl.sv
// Bench for dmem_latency_ctrl: a table of directed requests plus hand-written sequences for stall, reset abort and posted stores.
module tb_dmem_latency_ctrl;
    localparam int LAT = 4;
    localparam int NV  = 11;
`ifdef DMEM_POSTED_WRITE_EN
    localparam int          SLAT      = 1;
    localparam logic [31:0] ABORT_EXP = 32'hAAAA5555;
`else
    localparam int          SLAT      = LAT + 1;
    localparam logic [31:0] ABORT_EXP = 32'h11112222;
`endif

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          exp_lat;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t        vecs [NV];
    int          n_checks = 0;
    int          n_errors = 0;
    int          lat_n;
    logic [31:0] rd;
    logic        er;
    logic [2:0]  exp3;
    bit          seen;

    dmem_latency_ctrl #(.DEPTH_WORDS(16), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Issue one request from IDLE and count accept-to-response edges (accept edge counts as 1).
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output int n, output logic [31:0] rdata, output logic err);
        bit found = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        n = 0;
        while (!found && n < 20) begin
            @(posedge clk); #1;
            req_valid = 1'b0; req_addr = 32'hFFFF_FFFC; req_wdata = 32'h5A5A_5A5A;
            n++;
            @(negedge clk);
            if (resp_valid) found = 1'b1;
        end
        rdata = resp_rdata;
        err   = resp_err;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h10, 32'hDEADBEEF, SLAT,    32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h10, 32'h0,        LAT + 1, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 32'h13, 32'h0,        LAT + 1, 32'h0,        1'b1};
        vecs[3]  = '{1'b1, 32'h12, 32'hFFFFFFFF, LAT + 1, 32'h0,        1'b1};
        vecs[4]  = '{1'b0, 32'h10, 32'h0,        LAT + 1, 32'hDEADBEEF, 1'b0};
        vecs[5]  = '{1'b1, 32'h40, 32'h1234,     SLAT,    32'h0,        1'b0};
        vecs[6]  = '{1'b0, 32'h00, 32'h0,        LAT + 1, 32'h1234,     1'b0};
        vecs[7]  = '{1'b0, 32'h40, 32'h0,        LAT + 1, 32'h1234,     1'b0};
        vecs[8]  = '{1'b1, 32'h08, 32'hCAFEF00D, SLAT,    32'h0,        1'b0};
        vecs[9]  = '{1'b0, 32'h08, 32'h0,        LAT + 1, 32'hCAFEF00D, 1'b0};
        vecs[10] = '{1'b0, 32'h48, 32'h0,        LAT + 1, 32'hCAFEF00D, 1'b0};

        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        @(negedge clk); @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_stall_lo", 32'(stall), 32'd0);
        req_valid = 1'b1; #1;
        chk("rst_stall_hi", 32'(stall), 32'd1);
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat_n, rd, er);
            chk($sformatf("v%0d_latency", i), 32'(lat_n), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
        end

        // Load with req_valid held through RESP: the next accept happens only in the following IDLE.
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
        for (int k = 0; k < LAT + 4; k++) begin
            @(negedge clk);
            if (k == 0)                exp3 = 3'b110;
            else if (k <= LAT)         exp3 = 3'b100;
            else if (k == LAT + 1)     exp3 = 3'b001;
            else if (k == LAT + 2)     exp3 = 3'b110;
            else                       exp3 = 3'b100;
            chk($sformatf("stall_seq%0d_{stall,ready,resp}", k), 32'({stall, req_ready, resp_valid}), 32'(exp3));
            if (k == LAT + 1) chk("stall_seq_rdata", resp_rdata, 32'hDEADBEEF);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        seen = 1'b0;
        for (int w = 0; w < 20 && !seen; w++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
            else @(posedge clk);
        end
        chk("stall_drain_resp", 32'(seen), 32'd1);

        // Reset during the second BUSY cycle of a store must discard it.
        do_req(1'b1, 32'h20, 32'h11112222, lat_n, rd, er);
        do_req(1'b0, 32'h20, 32'h0, lat_n, rd, er);
        chk("abort_pre_rdata", rd, 32'h11112222);
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hAAAA5555;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_rdata", resp_rdata, 32'h0);
        chk("abort_err", 32'(resp_err), 32'd0);
        chk("abort_stall_lo", 32'(stall), 32'd0);
        req_valid = 1'b1; #1;
        chk("abort_stall_hi", 32'(stall), 32'd1);
        req_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("abort_no_resp%0d", c), 32'(resp_valid), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        do_req(1'b0, 32'h20, 32'h0, lat_n, rd, er);
        chk("abort_post_latency", 32'(lat_n), 32'(LAT + 1));
        chk("abort_post_rdata", rd, ABORT_EXP);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
